// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IE/IF registers, IME with delayed EI, and a
// request/ack dispatch handshake that presents a vector at instruction
// boundaries. Also drives the HALT wake indication.
module sm83_irq_ctrl #(
   parameter int          N_SRC      = 5,
   parameter logic [15:0] VEC_BASE   = 16'h0040,
   parameter logic [15:0] VEC_STRIDE = 16'h0008,
   parameter int          EI_DELAY   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq_set_i,
   input  logic             reg_we_i,
   input  logic             reg_sel_i,
   input  logic [7:0]       reg_wdata_i,
   output logic [7:0]       if_o,
   output logic [7:0]       ie_o,
   input  logic             instr_boundary_i,
   input  logic             ei_i,
   input  logic             di_i,
   input  logic             reti_i,
   output logic             ime_o,
   output logic             wake_o,
   output logic             dispatch_req_o,
   output logic [15:0]      dispatch_vec_o,
   input  logic             dispatch_ack_i
);

   typedef enum logic {IDLE, REQ} state_t;

   // Bits of IF above the implemented sources always read back as 1.
   localparam logic [7:0] IF_FORCED   = ~((8'h01 << N_SRC) - 8'h01);
   localparam logic [1:0] EI_CNT_INIT = 2'(EI_DELAY);

   state_t           state;
   state_t           state_next;
   logic [N_SRC-1:0] if_reg;
   logic [N_SRC-1:0] if_next;
   logic [N_SRC-1:0] pending;
   logic [7:0]       ie_reg;
   logic [7:0]       if_ext;
   logic             ime;
   logic             ei_arm;
   logic [1:0]       ei_cnt;
   logic [2:0]       idx;
   logic [15:0]      vec;
   logic             take;
   logic             ack_take;

   // Lowest-numbered set bit wins (source 0 has highest priority).
   function automatic logic [2:0] lowest_set(input logic [N_SRC-1:0] p);
      logic [2:0] r;
      r = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (p[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Vector arithmetic wraps at 16 bits.
   function automatic logic [15:0] vec_of(input logic [2:0] i);
      return VEC_BASE + 16'(i) * VEC_STRIDE;
   endfunction

   assign pending  = ie_reg[N_SRC-1:0] & if_reg;
   assign take     = (state == IDLE) && instr_boundary_i && ime && (|pending);
   assign ack_take = (state == REQ) && dispatch_ack_i;
   assign wake_o   = |pending;
   assign ime_o    = ime;
   assign ie_o     = ie_reg;
   assign dispatch_vec_o = vec;

   // IF readback with unimplemented bits forced high.
   always_comb begin
      if_ext = '0;
      if_ext[N_SRC-1:0] = if_reg;
      if_o = if_ext | IF_FORCED;
   end

   // IF next value: bus write, then ack clear, then new requests on top.
   always_comb begin
      if_next = if_reg;
      if (reg_we_i && !reg_sel_i) if_next = reg_wdata_i[N_SRC-1:0];
      if (ack_take) begin
         for (int i = 0; i < N_SRC; i++) begin
            if (idx == 3'(i)) if_next[i] = 1'b0;
         end
      end
      if_next = if_next | irq_set_i;
   end

   // IE/IF register storage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_reg <= '0;
         ie_reg <= '0;
      end else begin
         if_reg <= if_next;
         if (reg_we_i && reg_sel_i) ie_reg <= reg_wdata_i;
      end
   end

   // IME and EI countdown; ack outranks DI, which outranks RETI, then EI.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ime    <= 1'b0;
         ei_arm <= 1'b0;
         ei_cnt <= '0;
      end else if (ack_take || di_i) begin
         ime    <= 1'b0;
         ei_arm <= 1'b0;
      end else if (reti_i) begin
         ime    <= 1'b1;
         ei_arm <= 1'b0;
      end else if (ei_i) begin
         ei_arm <= 1'b1;
         ei_cnt <= EI_CNT_INIT;
      end else if (ei_arm) begin
         if (ei_cnt == 2'd0) begin
            ime    <= 1'b1;
            ei_arm <= 1'b0;
         end else if (instr_boundary_i) begin
            if (ei_cnt == 2'd1) begin
               ime    <= 1'b1;
               ei_arm <= 1'b0;
            end else begin
               ei_cnt <= ei_cnt - 2'd1;
            end
         end
      end
   end

   // Dispatch FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Dispatch FSM next-state and request output.
   always_comb begin
      state_next     = state;
      dispatch_req_o = 1'b0;
      case (state)
         IDLE: if (take) state_next = REQ;
         REQ: begin
            dispatch_req_o = 1'b1;
            if (dispatch_ack_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Latch the winning source and its vector when a request is raised; both
   // stay frozen for the whole REQ phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx <= '0;
         vec <= VEC_BASE;
      end else if (take) begin
         idx <= lowest_set(pending);
         vec <= vec_of(lowest_set(pending));
      end
   end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Testbench for sm83_irq_ctrl: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the controller.
module tb_sm83_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  irq_set;
   logic        reg_we, reg_sel;
   logic [7:0]  wdata;
   logic [7:0]  if_o, ie_o;
   logic        boundary, ei, di, reti, ack;
   logic        ime_o, wake_o, req_o;
   logic [15:0] vec_o;

   logic [7:0]  p8_irq_set;
   logic        p8_we, p8_sel, p8_boundary, p8_ei, p8_di, p8_reti, p8_ack;
   logic [7:0]  p8_wdata, p8_if_o, p8_ie_o;
   logic        p8_ime_o, p8_wake_o, p8_req_o;
   logic [15:0] p8_vec_o;

   int total = 0;
   int bad   = 0;

   // model state
   logic [4:0]  m_if;
   logic [7:0]  m_ie;
   logic        m_ime, m_arm, m_req;
   int          m_cnt, m_idx;
   logic [15:0] m_vec;

   always #5 clk = ~clk;

   sm83_irq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .irq_set_i(irq_set), .reg_we_i(reg_we),
      .reg_sel_i(reg_sel), .reg_wdata_i(wdata), .if_o(if_o), .ie_o(ie_o),
      .instr_boundary_i(boundary), .ei_i(ei), .di_i(di), .reti_i(reti),
      .ime_o(ime_o), .wake_o(wake_o), .dispatch_req_o(req_o),
      .dispatch_vec_o(vec_o), .dispatch_ack_i(ack)
   );

   sm83_irq_ctrl #(.N_SRC(8), .VEC_BASE(16'h0100), .VEC_STRIDE(16'h0010), .EI_DELAY(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .irq_set_i(p8_irq_set), .reg_we_i(p8_we),
      .reg_sel_i(p8_sel), .reg_wdata_i(p8_wdata), .if_o(p8_if_o), .ie_o(p8_ie_o),
      .instr_boundary_i(p8_boundary), .ei_i(p8_ei), .di_i(p8_di), .reti_i(p8_reti),
      .ime_o(p8_ime_o), .wake_o(p8_wake_o), .dispatch_req_o(p8_req_o),
      .dispatch_vec_o(p8_vec_o), .dispatch_ack_i(p8_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural model: computes the state after the coming edge from the
   // current state and the inputs being driven.
   task automatic model_step();
      logic [4:0] pend, nif;
      logic [7:0] nie;
      logic       take_ack, nime, narm, nreq;
      int         ncnt, left;
      if (!rst_n) begin
         m_if = '0; m_ie = '0; m_ime = 1'b0; m_arm = 1'b0; m_cnt = 0;
         m_req = 1'b0; m_vec = 16'h0040; m_idx = 0;
         return;
      end
      take_ack = m_req && ack;
      pend = m_ie[4:0] & m_if;
      nif = m_if;
      if (reg_we && !reg_sel) nif = wdata[4:0];
      if (take_ack) nif[m_idx] = 1'b0;
      nif = nif | irq_set;
      nie = (reg_we && reg_sel) ? wdata : m_ie;
      nime = m_ime; narm = m_arm; ncnt = m_cnt;
      if (take_ack || di) begin
         nime = 1'b0; narm = 1'b0;
      end else if (reti) begin
         nime = 1'b1; narm = 1'b0;
      end else if (ei) begin
         narm = 1'b1; ncnt = 1;
      end else if (m_arm) begin
         left = m_cnt - (boundary ? 1 : 0);
         if (left <= 0) begin
            nime = 1'b1; narm = 1'b0;
         end else ncnt = left;
      end
      nreq = m_req;
      if (take_ack) nreq = 1'b0;
      else if (!m_req && boundary && m_ime && pend != 0) begin
         nreq = 1'b1;
         for (int i = 4; i >= 0; i--) if (pend[i]) m_idx = i;
         m_vec = 16'(32'h0040 + m_idx * 8);
      end
      m_if = nif; m_ie = nie; m_ime = nime; m_arm = narm; m_cnt = ncnt; m_req = nreq;
   endtask

   task automatic idle_inputs();
      irq_set = '0; reg_we = 0; reg_sel = 0; wdata = '0;
      boundary = 0; ei = 0; di = 0; reti = 0; ack = 0;
      p8_irq_set = '0; p8_we = 0; p8_sel = 0; p8_wdata = '0;
      p8_boundary = 0; p8_ei = 0; p8_di = 0; p8_reti = 0; p8_ack = 0;
   endtask

   // One clock: advance model, take the edge, compare all outputs.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("if_o", {24'h0, if_o}, {24'h0, 8'hE0 | {3'b000, m_if}});
      chk("ie_o", {24'h0, ie_o}, {24'h0, m_ie});
      chk("ime_o", {31'h0, ime_o}, {31'h0, m_ime});
      chk("req_o", {31'h0, req_o}, {31'h0, m_req});
      chk("vec_o", {16'h0, vec_o}, {16'h0, m_vec});
      chk("wake_o", {31'h0, wake_o}, {31'h0, |(m_ie[4:0] & m_if)});
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      m_if = '0; m_ie = '0; m_ime = 0; m_arm = 0; m_cnt = 0; m_req = 0; m_vec = 16'h0040; m_idx = 0;

      // reset with requests asserted
      rst_n = 0; irq_set = 5'h1F; p8_irq_set = 8'hFF; tick();
      irq_set = 5'h1F; p8_irq_set = 8'hFF; tick();
      chk("rst_if", {24'h0, if_o}, 32'hE0);
      chk("rst_ie", {24'h0, ie_o}, 32'h00);
      chk("rst_ime", {31'h0, ime_o}, 32'h0);
      chk("rst_req", {31'h0, req_o}, 32'h0);
      chk("rst_vec", {16'h0, vec_o}, 32'h0040);
      chk("rst_p8_if", {24'h0, p8_if_o}, 32'h00);
      rst_n = 1;

      // priority between sources 2 and 4
      reg_we = 1; reg_sel = 1; wdata = 8'h1F; tick();
      irq_set = 5'b10100; tick();
      reti = 1; tick();
      chk("prio_ime", {31'h0, ime_o}, 32'h1);
      boundary = 1; tick();
      chk("prio_req", {31'h0, req_o}, 32'h1);
      chk("prio_vec", {16'h0, vec_o}, 32'h0050);
      irq_set = 5'b00001; tick();
      chk("prio_vec_hold", {16'h0, vec_o}, 32'h0050);
      reg_we = 1; reg_sel = 0; wdata = 8'h14; tick();
      ack = 1; tick();
      chk("prio_ack_if", {24'h0, if_o}, 32'hF0);
      chk("prio_ack_ime", {31'h0, ime_o}, 32'h0);
      chk("prio_ack_req", {31'h0, req_o}, 32'h0);

      // EI shadow
      reg_we = 1; reg_sel = 0; wdata = 8'h00; tick();
      reg_we = 1; reg_sel = 1; wdata = 8'h01; tick();
      irq_set = 5'h01; tick();
      ei = 1; tick();
      chk("ei_armed_ime", {31'h0, ime_o}, 32'h0);
      boundary = 1; tick();
      chk("ei_b1_req", {31'h0, req_o}, 32'h0);
      chk("ei_b1_ime", {31'h0, ime_o}, 32'h1);
      boundary = 1; tick();
      chk("ei_b2_req", {31'h0, req_o}, 32'h1);
      chk("ei_b2_vec", {16'h0, vec_o}, 32'h0040);

      // set coincident with ack of the same source
      ack = 1; irq_set = 5'h01; tick();
      chk("race_if0", {31'h0, if_o[0]}, 32'h1);
      chk("race_req", {31'h0, req_o}, 32'h0);
      reti = 1; tick();
      di = 1; reti = 1; tick();
      chk("race_di_reti", {31'h0, ime_o}, 32'h0);

      // ack while idle is ignored
      ack = 1; tick();
      chk("idle_ack_if0", {31'h0, if_o[0]}, 32'h1);

      // HALT wake without IME
      reg_we = 1; reg_sel = 0; wdata = 8'h00; tick();
      reg_we = 1; reg_sel = 1; wdata = 8'h04; tick();
      chk("halt_wake0", {31'h0, wake_o}, 32'h0);
      irq_set = 5'h04; tick();
      chk("halt_wake1", {31'h0, wake_o}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         boundary = 1; tick();
         chk("halt_noreq", {31'h0, req_o}, 32'h0);
      end

      // 8-source instance
      p8_irq_set = 8'h80; tick();
      chk("p8_if", {24'h0, p8_if_o}, 32'h80);
      p8_we = 1; p8_sel = 1; p8_wdata = 8'hFF; tick();
      chk("p8_wake", {31'h0, p8_wake_o}, 32'h1);
      p8_reti = 1; tick();
      p8_boundary = 1; tick();
      chk("p8_req", {31'h0, p8_req_o}, 32'h1);
      chk("p8_vec", {16'h0, p8_vec_o}, 32'h0170);
      p8_ack = 1; tick();
      chk("p8_ack_req", {31'h0, p8_req_o}, 32'h0);
      chk("p8_ack_if", {24'h0, p8_if_o}, 32'h00);
      chk("p8_ack_ime", {31'h0, p8_ime_o}, 32'h0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         rst_n    = ($urandom_range(0, 149) != 0);
         irq_set  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
         reg_we   = ($urandom_range(0, 7) == 0);
         reg_sel  = 1'($urandom);
         wdata    = 8'($urandom);
         boundary = ($urandom_range(0, 2) == 0);
         ei       = ($urandom_range(0, 9) == 0);
         di       = ($urandom_range(0, 24) == 0);
         reti     = ($urandom_range(0, 14) == 0);
         ack      = ($urandom_range(0, 2) == 0);
         tick();
      end
      rst_n = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
